// File: rtl/onchip_ram_fifo_ctrl.sv
// FIFO controller that streams words through a single-port on-chip RAM with a one-word output register.
// Optional occupancy output `level` is enabled by defining ONCHIP_RAM_FIFO_CTRL_LEVEL_EN.
module onchip_ram_fifo_ctrl #(
  parameter int unsigned ADDR_W = 13,
  parameter int unsigned DATA_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clear,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_W-1:0]   in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_W-1:0]   out_data,
  output logic [ADDR_W-1:0]   ram_address,
  output logic                ram_chipselect,
  output logic                ram_write,
  output logic                ram_clken,
  output logic [DATA_W/8-1:0] ram_byteenable,
  output logic [DATA_W-1:0]   ram_writedata,
  input  logic [DATA_W-1:0]   ram_readdata
`ifdef ONCHIP_RAM_FIFO_CTRL_LEVEL_EN
  ,
  output logic [ADDR_W+1:0]   level
`endif
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam int unsigned LVL_W = ADDR_W + 2;
  localparam logic [CNT_W-1:0] DEPTH = CNT_W'(1) << ADDR_W;

  logic [ADDR_W-1:0] wr_ptr, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr, rd_ptr_d;
  logic [CNT_W-1:0]  ram_count, ram_count_d;
  logic              rd_pend, rd_pend_d;
  logic              out_valid_d;
  logic [DATA_W-1:0] out_data_d;
  logic              rd_issue;
  logic              wr_beat;

  // One RAM access per cycle; a read wins over a write so the output register refills promptly.
  always_comb begin
    rd_issue = !reset && !clear && (ram_count != '0) && !rd_pend && (!out_valid || out_ready);
    in_ready = !reset && !clear && (ram_count != DEPTH) && !rd_issue;
    wr_beat  = in_valid && in_ready;
  end

  always_comb begin
    ram_chipselect = wr_beat || rd_issue;
    ram_write      = wr_beat;
    ram_address    = wr_beat ? wr_ptr : rd_ptr;
    ram_clken      = 1'b1;
    ram_byteenable = '1;
    ram_writedata  = in_data;
  end

  // Next state: the output register is always empty when read data returns, so capture is unconditional.
  always_comb begin
    wr_ptr_d    = wr_ptr;
    rd_ptr_d    = rd_ptr;
    ram_count_d = ram_count;
    rd_pend_d   = rd_pend;
    out_valid_d = out_valid;
    out_data_d  = out_data;
    if (clear) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      ram_count_d = '0;
      rd_pend_d   = 1'b0;
      out_valid_d = 1'b0;
    end else begin
      if (wr_beat) begin
        wr_ptr_d    = wr_ptr + ADDR_W'(1);
        ram_count_d = ram_count + CNT_W'(1);
      end
      if (rd_issue) begin
        rd_ptr_d    = rd_ptr + ADDR_W'(1);
        ram_count_d = ram_count - CNT_W'(1);
      end
      rd_pend_d = rd_issue;
      if (rd_pend) begin
        out_data_d  = ram_readdata;
        out_valid_d = 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      ram_count <= '0;
      rd_pend   <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      wr_ptr    <= wr_ptr_d;
      rd_ptr    <= rd_ptr_d;
      ram_count <= ram_count_d;
      rd_pend   <= rd_pend_d;
      out_valid <= out_valid_d;
      out_data  <= out_data_d;
    end
  end

`ifdef ONCHIP_RAM_FIFO_CTRL_LEVEL_EN
  // Words held anywhere in the controller: RAM, in-flight read, output register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      level <= '0;
    end else begin
      level <= LVL_W'(ram_count_d) + LVL_W'(rd_pend_d) + LVL_W'(out_valid_d);
    end
  end
`endif

endmodule

// File: tb/tb_onchip_ram_fifo_ctrl.sv
// Scoreboard bench for onchip_ram_fifo_ctrl with a behavioural single-port RAM and an ordered-queue reference.
module tb_onchip_ram_fifo_ctrl;

  localparam int unsigned ADDR_W = 3;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned DEPTH  = 1 << ADDR_W;

  logic                clk;
  logic                reset;
  logic                clear;
  logic                in_valid;
  logic                in_ready;
  logic [DATA_W-1:0]   in_data;
  logic                out_valid;
  logic                out_ready;
  logic [DATA_W-1:0]   out_data;
  logic [ADDR_W-1:0]   ram_address;
  logic                ram_chipselect;
  logic                ram_write;
  logic                ram_clken;
  logic [DATA_W/8-1:0] ram_byteenable;
  logic [DATA_W-1:0]   ram_writedata;
  logic [DATA_W-1:0]   ram_readdata;
`ifdef ONCHIP_RAM_FIFO_CTRL_LEVEL_EN
  logic [ADDR_W+1:0]   level;
`endif

  onchip_ram_fifo_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk            (clk),
    .reset          (reset),
    .clear          (clear),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_data        (in_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .ram_address    (ram_address),
    .ram_chipselect (ram_chipselect),
    .ram_write      (ram_write),
    .ram_clken      (ram_clken),
    .ram_byteenable (ram_byteenable),
    .ram_writedata  (ram_writedata),
    .ram_readdata   (ram_readdata)
`ifdef ONCHIP_RAM_FIFO_CTRL_LEVEL_EN
    ,
    .level          (level)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single-port RAM: read data registered one clock after the address.
  logic [DATA_W-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (ram_clken && ram_chipselect) begin
      if (ram_write) mem[ram_address] <= ram_writedata;
      else           ram_readdata     <= mem[ram_address];
    end
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: words accepted and not yet delivered, in order.
  logic [DATA_W-1:0] q[$];
  int                n_acc = 0;
  logic              hold_prev = 1'b0;
  logic [DATA_W-1:0] prev_data = '0;
  logic [ADDR_W-1:0] last_wa = '0;
  logic [ADDR_W-1:0] last_ra = '0;
  logic              wr_wrap = 1'b0;
  logic              rd_wrap = 1'b0;

  always @(negedge clk) begin
    if (reset || clear) begin
      q.delete();
    end else begin
`ifdef ONCHIP_RAM_FIFO_CTRL_LEVEL_EN
      check("level", 64'(level), 64'(q.size()));
`endif
      if (hold_prev) check("hold", {31'b0, out_valid, out_data}, {31'b0, 1'b1, prev_data});
      if (out_valid && out_ready) begin
        if (q.size() == 0) check("pop_when_empty", 64'(out_data), 64'hDEAD_0000_0000_0000);
        else check("out_data", 64'(out_data), 64'(q.pop_front()));
      end
      if (in_valid && in_ready) begin
        q.push_back(in_data);
        n_acc++;
      end
      if (ram_chipselect && ram_write) begin
        if (last_wa == ADDR_W'(DEPTH - 1) && ram_address == '0) wr_wrap = 1'b1;
        last_wa = ram_address;
      end
      if (ram_chipselect && !ram_write) begin
        if (last_ra == ADDR_W'(DEPTH - 1) && ram_address == '0) rd_wrap = 1'b1;
        last_ra = ram_address;
      end
    end
    hold_prev = !reset && !clear && out_valid && !out_ready;
    prev_data = out_data;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while ((out_valid || q.size() != 0) && n < 200) begin
      step();
      n++;
    end
    check("drain_done", 64'(n < 200), 64'(1));
  endtask

  int                acc;
  int                n;
  int                reads;
  logic [DATA_W-1:0] held;

  initial begin
    reset     = 1'b1;
    clear     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    #1;
    check("rst_in_ready",  64'(in_ready),       64'(0));
    check("rst_cs",        64'(ram_chipselect), 64'(0));
    check("rst_write",     64'(ram_write),      64'(0));
    check("rst_addr",      64'(ram_address),    64'(0));
    check("rst_clken",     64'(ram_clken),      64'(1));
    check("rst_be",        64'(ram_byteenable), 64'hF);
    check("rst_out_valid", 64'(out_valid),      64'(0));
    check("rst_out_data",  64'(out_data),       64'(0));
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    step();

    // Single word latency and address sequence
    in_valid  = 1'b1;
    in_data   = 32'h1111_1111;
    out_ready = 1'b1;
    @(negedge clk);
    check("lat_wr_ready", 64'(in_ready), 64'(1));
    check("lat_wr_ctl", {62'b0, ram_chipselect, ram_write}, 64'b11);
    check("lat_wr_addr", 64'(ram_address), 64'(0));
    check("wrdata", 64'(ram_writedata), 64'h1111_1111);
    step();
    in_valid = 1'b0;
    @(negedge clk);
    check("lat_rd_ctl", {62'b0, ram_chipselect, ram_write}, 64'b10);
    check("lat_rd_addr", 64'(ram_address), 64'(0));
    check("lat_t1_valid", 64'(out_valid), 64'(0));
    step();
    @(negedge clk);
    check("lat_t2_valid", 64'(out_valid), 64'(0));
    step();
    @(negedge clk);
    check("lat_t3_valid", 64'(out_valid), 64'(1));
    check("lat_t3_data", 64'(out_data), 64'h1111_1111);
    step();
    @(negedge clk);
    check("lat_fall", 64'(out_valid), 64'(0));
    step();

    // Fill with the sink stalled: DEPTH words in RAM plus one in the output register
    out_ready = 1'b0;
    acc = 0;
    for (int i = 0; i < 30; i++) begin
      in_valid = 1'b1;
      in_data  = $urandom;
      @(negedge clk);
      if (in_valid && in_ready) acc++;
      step();
    end
    in_valid = 1'b0;
    check("full_accepted", 64'(acc), 64'(DEPTH + 1));
    check("full_valid", 64'(out_valid), 64'(1));

    // Stalled output: data stable and no read issued
    held  = out_data;
    reads = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (ram_chipselect && !ram_write) reads++;
      step();
    end
    check("stall_reads", 64'(reads), 64'(0));
    check("stall_data", 64'(out_data), 64'(held));
    drain();

    // Random stream with random handshakes
    n   = 0;
    acc = n_acc;
    while (n_acc - acc < 24 && n < 400) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = $urandom;
      out_ready = ($urandom_range(0, 3) != 0);
      step();
      n++;
    end
    check("stream_len", 64'(n < 400), 64'(1));
    drain();
    check("wr_ptr_wrap", 64'(wr_wrap), 64'(1));
    check("rd_ptr_wrap", 64'(rd_wrap), 64'(1));

    // Clear right after a read issue
    out_ready = 1'b0;
    acc = 0;
    n   = 0;
    while (acc < 4 && n < 50) begin
      in_valid = 1'b1;
      in_data  = $urandom;
      @(negedge clk);
      if (in_ready) acc++;
      step();
      n++;
    end
    in_valid = 1'b0;
    repeat (3) step();
    out_ready = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if ((ram_chipselect && !ram_write) || n >= 10) break;
      step();
      n++;
    end
    check("clr_issue_seen", 64'(n < 10), 64'(1));
    @(posedge clk);
    #1;
    clear     = 1'b1;
    out_ready = 1'b0;
    @(negedge clk);
    check("clr_no_access", 64'(ram_chipselect), 64'(0));
    check("clr_in_ready", 64'(in_ready), 64'(0));
    step();
    clear = 1'b0;
    @(negedge clk);
    check("clr_out_valid", 64'(out_valid), 64'(0));
`ifdef ONCHIP_RAM_FIFO_CTRL_LEVEL_EN
    check("clr_level", 64'(level), 64'(0));
`endif
    step();
    in_valid  = 1'b1;
    in_data   = 32'hCAFE_F00D;
    out_ready = 1'b1;
    @(negedge clk);
    check("clr_wr_addr", {63'b0, in_ready}, 64'(1));
    check("clr_wr_ptr0", 64'(ram_address), 64'(0));
    step();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 10) begin
      step();
      n++;
    end
    check("clr_post_data", 64'(out_data), 64'hCAFE_F00D);
    drain();

    // Asynchronous reset between clock edges mid-stream
    for (int i = 0; i < 6; i++) begin
      in_valid  = 1'b1;
      in_data   = $urandom;
      out_ready = 1'($urandom_range(0, 1));
      step();
    end
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    check("arst_out_valid", 64'(out_valid),      64'(0));
    check("arst_in_ready",  64'(in_ready),       64'(0));
    check("arst_cs",        64'(ram_chipselect), 64'(0));
    check("arst_addr",      64'(ram_address),    64'(0));
    check("arst_out_data",  64'(out_data),       64'(0));
    @(posedge clk);
    #1;
    check("arst_hold_ready", 64'(in_ready), 64'(0));
    in_valid = 1'b0;
    #2 reset = 1'b0;
    step();
    in_valid  = 1'b1;
    in_data   = 32'h5A5A_A5A5;
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 10) begin
      step();
      n++;
    end
    check("arst_first_word", 64'(out_data), 64'h5A5A_A5A5);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
